// File: rtl/sr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_pkg
//  Description : Shared types and constants for the gated SR latch driver.
//                Holds the controller state encoding and the widths of the
//                phase and retry counters.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_pkg;

    // Phase counters are loaded on phase entry and count down to zero, so a
    // 4-bit counter covers every phase length from 1 to 15 cycles.
    localparam int c_phase_w = 4;

    // Retry counter width; saturates at MAX_RETRY (at most 7).
    localparam int c_retry_w = 3;

    // Cycles CHECK idles before sampling the synchronized latch output.
    localparam logic [c_phase_w-1:0] c_check_wait = 4'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer bringing an asynchronous level into
//                the clk domain.
//  Ports       : clk - rising-edge clock
//                rst - asynchronous active-high reset, clears both flops
//                d   - asynchronous input level
//                q   - synchronized level, two cycles behind d
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sr_latch_driver
//  Description : Writes an external gated SR latch. A request sets up S/R,
//                pulses the gate C, holds S/R, then reads back Q through a
//                synchronizer and retries on mismatch.
//  Ports       : clk       - rising-edge clock
//                rst       - asynchronous active-high reset
//                req_valid - write request present
//                req_val   - value to write (1 = set, 0 = reset)
//                req_ready - request accepted (high only in IDLE)
//                S, R, C   - registered set / reset / gate drives to the latch
//                Q_fb      - latch output, asynchronous to clk
//                done      - one-cycle pulse on a verified write
//                err       - one-cycle pulse when all retries fail
//                busy      - high in every state except IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int SETUP_CYC = 2,   // 1..15
    parameter int PULSE_CYC = 3,   // 1..15
    parameter int HOLD_CYC  = 2,   // 1..15
    parameter int MAX_RETRY = 3    // 0..7
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    output logic S,
    output logic R,
    output logic C,
    input  logic Q_fb,
    output logic done,
    output logic err,
    output logic busy
);

    // Counters count down to zero, so a phase of N cycles loads N-1.
    localparam logic [c_phase_w-1:0] c_setup_ld = c_phase_w'(SETUP_CYC - 1);
    localparam logic [c_phase_w-1:0] c_pulse_ld = c_phase_w'(PULSE_CYC - 1);
    localparam logic [c_phase_w-1:0] c_hold_ld  = c_phase_w'(HOLD_CYC - 1);
    localparam logic [c_retry_w-1:0] c_max_retry = c_retry_w'(MAX_RETRY);
    localparam logic [c_phase_w-1:0] c_cnt_one  = c_phase_w'(1);
    localparam logic [c_retry_w-1:0] c_retry_one = c_retry_w'(1);

    state_t                 r_state;
    logic [c_phase_w-1:0]   r_cnt;
    logic [c_retry_w-1:0]   r_retry;
    logic                   r_val;
    logic                   r_q_smp;
    logic                   r_smp_vld;
    logic                   r_s;
    logic                   r_r;
    logic                   r_c;
    logic                   r_done;
    logic                   r_err;
    logic                   w_q_sync;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (Q_fb),
        .q   (w_q_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_val     <= 1'b0;
            r_q_smp   <= 1'b0;
            r_smp_vld <= 1'b0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_c       <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // req_ready is high exactly in IDLE, so req_valid alone
                    // marks a transfer here.
                    if (req_valid) begin
                        r_val   <= req_val;
                        r_retry <= '0;
                        r_s     <= req_val;
                        r_r     <= ~req_val;
                        r_c     <= 1'b0;
                        r_cnt   <= c_setup_ld;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_c     <= 1'b1;
                        r_cnt   <= c_pulse_ld;
                        r_state <= PULSE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_c     <= 1'b0;
                        r_cnt   <= c_hold_ld;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_s       <= 1'b0;
                        r_r       <= 1'b0;
                        r_cnt     <= c_check_wait;
                        r_smp_vld <= 1'b0;
                        r_state   <= CHECK;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                CHECK: begin
                    // Idle for the settle window, take one registered sample
                    // of the synchronized Q, then act on it the cycle after.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else if (!r_smp_vld) begin
                        r_q_smp   <= w_q_sync;
                        r_smp_vld <= 1'b1;
                    end else if (r_q_smp == r_val) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_retry < c_max_retry) begin
                        r_retry <= r_retry + c_retry_one;
                        r_s     <= r_val;
                        r_r     <= ~r_val;
                        r_cnt   <= c_setup_ld;
                        r_state <= SETUP;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                ERR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign S         = r_s;
    assign R         = r_r;
    assign C         = r_c;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = (r_state != IDLE);
    assign req_ready = (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_latch_driver
//  Description : Directed self-checking bench for sr_latch_driver with a
//                behavioural gated SR latch on S/R/C driving Q_fb.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch_driver;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic req_valid = 1'b0;
    logic req_val   = 1'b0;
    logic q_stuck   = 1'b0;
    logic model_q   = 1'b0;
    logic req_ready, S, R, C, done, err, busy, Q_fb;

    int n_chk        = 0;
    int n_bad        = 0;
    int n_xfer       = 0;
    int n_assert_bad = 0;

    always #5 clk = ~clk;

    // Behavioural gated SR latch: transparent while C is high.
    always @(S or R or C) begin
        if (C) begin
            if (S)      model_q = 1'b1;
            else if (R) model_q = 1'b0;
        end
    end

    assign Q_fb = q_stuck ? 1'b0 : model_q;

    sr_latch_driver #(
        .SETUP_CYC (2),
        .PULSE_CYC (3),
        .HOLD_CYC  (2),
        .MAX_RETRY (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_val   (req_val),
        .req_ready (req_ready),
        .S         (S),
        .R         (R),
        .C         (C),
        .Q_fb      (Q_fb),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) n_xfer++;
    end

    // S and R are never both high, and never move while C is high or on
    // either edge of C.
    a_sr_excl: assert property (@(posedge clk) disable iff (rst) !(S && R))
        else begin
            n_assert_bad++;
            $display("FAIL sr_exclusive at %0t: S=%b R=%b", $time, S, R);
        end

    a_sr_stable: assert property (@(posedge clk) disable iff (rst)
                                  (C || $past(C)) |-> ($stable(S) && $stable(R)))
        else begin
            n_assert_bad++;
            $display("FAIL sr_stable_under_c at %0t: S=%b R=%b C=%b", $time, S, R, C);
        end

    task automatic chk(input string tag, input integer got, input integer exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Issues one request and samples #1 after each edge from the transfer
    // edge (k = 0) until the first done/err pulse or max_k.
    task automatic run_write(input logic val, input logic keep, input int max_k,
                             output int s_n, output int r_n, output int c_n,
                             output int c_rises, output int c_first,
                             output int done_k, output int err_k,
                             output int ready_hi);
        logic prev_c;
        prev_c = 1'b0;
        s_n = 0; r_n = 0; c_n = 0; c_rises = 0; c_first = -1;
        done_k = -1; err_k = -1; ready_hi = 0;
        req_val   = val;
        req_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= max_k; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            if (k == 0 && !keep) req_valid = 1'b0;
            s_n      += int'(S);
            r_n      += int'(R);
            c_n      += int'(C);
            ready_hi += int'(req_ready);
            if (C && !prev_c) begin
                c_rises++;
                if (c_first < 0) c_first = k;
            end
            prev_c = C;
            if (done && done_k < 0) done_k = k;
            if (err && err_k < 0) err_k = k;
            if (done || err) break;
        end
        req_valid = 1'b0;
    endtask

    task automatic post_idle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_err_low"}, err, 0);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_ready"}, req_ready, 1);
    endtask

    initial begin
        int s_n, r_n, c_n, c_rises, c_first, done_k, err_k, ready_hi, xfer0;
        int done_seen;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_C", C, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1);
        @(posedge clk);
        #1;

        // ---- set write ----
        run_write(1'b1, 1'b0, 30, s_n, r_n, c_n, c_rises, c_first, done_k, err_k, ready_hi);
        chk("set_S_cycles", s_n, 7);
        chk("set_R_cycles", r_n, 0);
        chk("set_C_cycles", c_n, 3);
        chk("set_C_rise_edge", c_first, 2);
        chk("set_done_edge", done_k, 11);
        chk("set_no_err", err_k, -1);
        chk("set_model_q", model_q, 1);
        post_idle("set");

        // ---- reset write ----
        run_write(1'b0, 1'b0, 30, s_n, r_n, c_n, c_rises, c_first, done_k, err_k, ready_hi);
        chk("clr_R_cycles", r_n, 7);
        chk("clr_S_cycles", s_n, 0);
        chk("clr_C_pulses", c_rises, 1);
        chk("clr_done_edge", done_k, 11);
        chk("clr_model_q", model_q, 0);
        post_idle("clr");

        // ---- request held high during a write ----
        xfer0 = n_xfer;
        run_write(1'b1, 1'b1, 30, s_n, r_n, c_n, c_rises, c_first, done_k, err_k, ready_hi);
        chk("busy_ready_low_samples", ready_hi, 0);
        chk("busy_done_edge", done_k, 11);
        post_idle("busy");
        chk("busy_one_transfer", n_xfer - xfer0, 1);
        chk("busy_model_q", model_q, 1);

        // ---- retry exhaustion with Q_fb stuck low ----
        q_stuck = 1'b1;
        run_write(1'b1, 1'b0, 60, s_n, r_n, c_n, c_rises, c_first, done_k, err_k, ready_hi);
        chk("retry_C_pulses", c_rises, 4);
        chk("retry_S_cycles", s_n, 28);
        chk("retry_err_edge", err_k, 44);
        chk("retry_no_done", done_k, -1);
        post_idle("retry");
        q_stuck = 1'b0;

        // ---- reset in the second PULSE cycle ----
        req_val   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_C_before", C, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_C", C, 0);
        chk("midrst_S", S, 0);
        chk("midrst_R", R, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready", req_ready, 1);
        done_seen = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            done_seen += int'(done) + int'(err);
        end
        chk("midrst_no_done_err", done_seen, 0);

        chk("assertion_failures", n_assert_bad, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
